pipeline_ctrl: RTL and testbench

Parametrised stage-control block for the N-stage in-order pipeline. It generalises the single global stall/freeze enable into per-stage hold, bubble insertion and flush. It shadows per-register occupancy, runs a halt drain FSM that waits for outstanding memory, and keeps saturating performance counters. It sits beside the pipeline registers in the datapath and drives their en/zero pins.

---
 rtl/pipeline_ctrl.sv | 93 +++++++++
 tb/tb_pipeline_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: per-stage hold/bubble/flush enables, occupancy shadow, halt drain FSM
// and saturating performance counters for an NSTAGES in-order pipeline.
module pipeline_ctrl #(
    parameter int NSTAGES = 5,
    parameter int CNT_W   = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [NSTAGES-1:0] stall_req,
    input  logic [NSTAGES-1:0] flush_req,
    input  logic               fetch_valid,
    input  logic               halt_req,
    input  logic               mem_busy,
    output logic [NSTAGES-1:0] en,
    output logic [NSTAGES-1:0] zero,
    output logic [NSTAGES-1:0] valid,
    output logic               halt,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_count,
    output logic [CNT_W-1:0]   retired_count
);
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

    state_t             r_state, w_next;
    logic [NSTAGES-1:0] r_valid, w_hold, w_flushed, w_shift;
    logic               r_halt, w_run;
    logic [CNT_W-1:0]   r_stall, r_flush, r_ret;

    // nRST gates the enables so nothing loads while reset is held
    assign w_run   = nRST && (r_state == RUN);
    assign w_shift = {r_valid[NSTAGES-2:0], fetch_valid};

    always_comb begin
        w_hold                 = '0;
        w_flushed              = '0;
        w_hold[NSTAGES-1]      = stall_req[NSTAGES-1];
        for (int i = NSTAGES - 2; i >= 0; i--) begin
            w_hold[i]    = w_hold[i+1] | stall_req[i];
            w_flushed[i] = w_flushed[i+1] | flush_req[i+1];
        end
    end

    always_comb begin
        en      = '0;
        zero    = '0;
        zero[0] = w_run && (w_flushed[0] || !fetch_valid);
        for (int i = 0; i < NSTAGES; i++)
            en[i] = w_run && (!w_hold[i] || w_flushed[i]);
        for (int i = 1; i < NSTAGES; i++)
            zero[i] = w_run && (w_flushed[i] || (w_hold[i-1] && !w_hold[i]));
    end

    always_comb begin
        w_next = r_state;
        if (r_state == RUN && halt_req)
            w_next = DRAIN;
        else if (r_state == DRAIN && !mem_busy)
            w_next = HALTED;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
            r_valid <= '0;
            r_halt  <= 1'b0;
            r_stall <= '0;
            r_flush <= '0;
            r_ret   <= '0;
        end else begin
            r_state <= w_next;
            r_halt  <= r_halt || (w_next == HALTED);
            for (int i = 0; i < NSTAGES; i++)
                if (en[i])
                    r_valid[i] <= zero[i] ? 1'b0 : w_shift[i];
            if (r_state == RUN) begin
                if (|stall_req && !(&r_stall))
                    r_stall <= r_stall + CNT_W'(1);
                if (|flush_req && !(&r_flush))
                    r_flush <= r_flush + CNT_W'(1);
                if (en[NSTAGES-1] && r_valid[NSTAGES-1] && !(&r_ret))
                    r_ret <= r_ret + CNT_W'(1);
            end
        end
    end

    assign valid         = r_valid;
    assign halt          = r_halt;
    assign state         = r_state;
    assign stall_cycles  = r_stall;
    assign flush_count   = r_flush;
    assign retired_count = r_ret;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a
// stage-index reference model (oldest stall / oldest flush position).
module tb_pipeline_ctrl;
    localparam int N = 5;
    localparam longint MAX32 = 64'hFFFF_FFFF;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic [N-1:0] stall_req = '0, flush_req = '0;
    logic         fetch_valid = 1'b1, halt_req = 1'b0, mem_busy = 1'b0;

    logic [N-1:0] en, zero, valid, s_en, s_zero, s_valid;
    logic         halt, s_halt;
    logic [1:0]   state, s_state;
    logic [31:0]  stall_cycles, flush_count, retired_count;
    logic [3:0]   s_stall_cycles, s_flush_count, s_retired_count;

    pipeline_ctrl #(.NSTAGES(N), .CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .stall_req(stall_req), .flush_req(flush_req),
        .fetch_valid(fetch_valid), .halt_req(halt_req), .mem_busy(mem_busy),
        .en(en), .zero(zero), .valid(valid), .halt(halt), .state(state),
        .stall_cycles(stall_cycles), .flush_count(flush_count), .retired_count(retired_count)
    );

    pipeline_ctrl #(.NSTAGES(N), .CNT_W(4)) dut_s (
        .CLK(CLK), .nRST(nRST), .stall_req(stall_req), .flush_req(flush_req),
        .fetch_valid(fetch_valid), .halt_req(halt_req), .mem_busy(mem_busy),
        .en(s_en), .zero(s_zero), .valid(s_valid), .halt(s_halt), .state(s_state),
        .stall_cycles(s_stall_cycles), .flush_count(s_flush_count), .retired_count(s_retired_count)
    );

    always #5 CLK = ~CLK;

    int total = 0, bad = 0;

    logic [N-1:0] m_valid, x_en, x_zero;
    int           m_state;
    logic         m_halt;
    longint       m_stall, m_flush, m_ret;

    // Expected enables from the position of the oldest stall and oldest flush.
    task automatic model_comb();
        int s = -1;
        int f = -1;
        x_en   = '0;
        x_zero = '0;
        if (m_state == 0 && nRST) begin
            for (int i = 0; i < N; i++) begin
                if (stall_req[i]) s = i;
                if (flush_req[i]) f = i;
            end
            for (int i = 0; i < N; i++) begin
                x_en[i]   = (i < f) || (i > s);
                x_zero[i] = (i < f) || (s >= 0 && i == s + 1) || (i == 0 && !fetch_valid);
            end
        end
    endtask

    task automatic model_clear();
        m_valid = '0; m_state = 0; m_halt = 1'b0;
        m_stall = 0; m_flush = 0; m_ret = 0;
    endtask

    task automatic tick();
        model_comb();
        if (m_state == 0) begin
            if (x_en[N-1] && m_valid[N-1] && m_ret < MAX32) m_ret++;
            for (int i = N - 1; i >= 0; i--)
                if (x_en[i]) m_valid[i] = x_zero[i] ? 1'b0 : (i == 0 ? fetch_valid : m_valid[i-1]);
            if (|stall_req && m_stall < MAX32) m_stall++;
            if (|flush_req && m_flush < MAX32) m_flush++;
            if (halt_req) m_state = 1;
        end else if (m_state == 1 && !mem_busy) begin
            m_state = 2;
            m_halt  = 1'b1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        stall_req = '0; flush_req = '0; fetch_valid = 1'b1; halt_req = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 1'b0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge CLK);
        #2;
        idle_inputs();
        nRST = 1'b0;
        model_clear();
        #1;
        total++;
        if ({en, zero} !== 10'b0) begin
            bad++; $display("FAIL reset_en_zero got=%b exp=%b", {en, zero}, 10'b0);
        end
        total++;
        if ({valid, state, halt} !== 8'b0) begin
            bad++; $display("FAIL reset_state got=%b exp=%b", {valid, state, halt}, 8'b0);
        end
        total++;
        if ({stall_cycles, flush_count, retired_count} !== 96'b0) begin
            bad++; $display("FAIL reset_counters got=%0h exp=0", {stall_cycles, flush_count, retired_count});
        end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        #1;
        total++;
        if ({en, zero} !== 10'b11111_00000) begin
            bad++; $display("FAIL release_en_zero got=%b exp=%b", {en, zero}, 10'b11111_00000);
        end
    endtask

    task automatic test_fill();
        do_reset();
        repeat (8) tick();
        total++;
        if (valid !== 5'b11111) begin
            bad++; $display("FAIL fill_valid got=%b exp=%b", valid, 5'b11111);
        end
        total++;
        if (retired_count !== 32'd3) begin
            bad++; $display("FAIL fill_retired got=%0d exp=3", retired_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (8) tick();
        stall_req = 5'b00100;
        #1;
        total++;
        if ({en, zero} !== 10'b11000_01000) begin
            bad++; $display("FAIL stall_en_zero got=%b exp=%b", {en, zero}, 10'b11000_01000);
        end
        tick();
        stall_req = '0;
        total++;
        if (valid !== 5'b10111) begin
            bad++; $display("FAIL stall_valid got=%b exp=%b", valid, 5'b10111);
        end
        total++;
        if (stall_cycles !== 32'd1) begin
            bad++; $display("FAIL stall_count got=%0d exp=1", stall_cycles);
        end
    endtask

    task automatic test_flush();
        do_reset();
        repeat (8) tick();
        flush_req = 5'b01000;
        #1;
        total++;
        if ({en, zero} !== 10'b11111_00111) begin
            bad++; $display("FAIL flush_en_zero got=%b exp=%b", {en, zero}, 10'b11111_00111);
        end
        tick();
        flush_req = '0;
        total++;
        if (valid !== 5'b11000) begin
            bad++; $display("FAIL flush_valid got=%b exp=%b", valid, 5'b11000);
        end
        total++;
        if (flush_count !== 32'd1) begin
            bad++; $display("FAIL flush_count got=%0d exp=1", flush_count);
        end
    endtask

    task automatic test_flush_over_stall();
        do_reset();
        repeat (8) tick();
        flush_req = 5'b01000;
        stall_req = 5'b00010;
        #1;
        total++;
        if ({en, zero} !== 10'b11111_00111) begin
            bad++; $display("FAIL fos_en_zero got=%b exp=%b", {en, zero}, 10'b11111_00111);
        end
        tick();
        idle_inputs();
        total++;
        if ({stall_cycles, flush_count} !== {32'd1, 32'd1}) begin
            bad++; $display("FAIL fos_counts got=%0d/%0d exp=1/1", stall_cycles, flush_count);
        end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (8) tick();
        halt_req = 1'b1;
        mem_busy = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            stall_req = 5'($urandom);
            flush_req = 5'($urandom);
            #1;
            total++;
            if ({state, halt, en, zero} !== {2'd1, 1'b0, 10'b0}) begin
                bad++; $display("FAIL drain_cycle%0d got=%b exp=%b", c, {state, halt, en, zero}, {2'd1, 1'b0, 10'b0});
            end
            tick();
        end
        mem_busy = 1'b0;
        #1;
        total++;
        if ({state, halt} !== 3'b010) begin
            bad++; $display("FAIL drain_last got=%b exp=%b", {state, halt}, 3'b010);
        end
        tick();
        total++;
        if ({state, halt} !== 3'b101) begin
            bad++; $display("FAIL halted_entry got=%b exp=%b", {state, halt}, 3'b101);
        end
        halt_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            stall_req = 5'($urandom);
            flush_req = 5'($urandom);
            tick();
        end
        total++;
        if ({state, halt, en} !== {2'd2, 1'b1, 5'b0}) begin
            bad++; $display("FAIL halted_sticky got=%b exp=%b", {state, halt, en}, {2'd2, 1'b1, 5'b0});
        end
        total++;
        if ({stall_cycles, flush_count, retired_count} !== {m_stall[31:0], m_flush[31:0], m_ret[31:0]}) begin
            bad++; $display("FAIL halted_counters got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                stall_cycles, flush_count, retired_count, m_stall, m_flush, m_ret);
        end
        total++;
        if (retired_count !== 32'd4) begin
            bad++; $display("FAIL halted_retired got=%0d exp=4", retired_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            stall_req   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
            flush_req   = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'b0;
            fetch_valid = ($urandom_range(0, 3) != 0);
            halt_req    = ($urandom_range(0, 150) == 0);
            mem_busy    = ($urandom_range(0, 1) == 0);
            #1;
            model_comb();
            total++;
            if ({en, zero} !== {x_en, x_zero}) begin
                bad++; $display("FAIL rand_en_zero cyc=%0d got=%b exp=%b", c, {en, zero}, {x_en, x_zero});
            end
            tick();
            total++;
            if ({valid, state, halt} !== {m_valid, m_state[1:0], m_halt}) begin
                bad++; $display("FAIL rand_state cyc=%0d got=%b exp=%b", c, {valid, state, halt}, {m_valid, m_state[1:0], m_halt});
            end
            total++;
            if ({stall_cycles, flush_count, retired_count} !== {m_stall[31:0], m_flush[31:0], m_ret[31:0]}) begin
                bad++; $display("FAIL rand_counters cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                    c, stall_cycles, flush_count, retired_count, m_stall, m_flush, m_ret);
            end
            if (m_state == 2 && $urandom_range(0, 3) == 0) do_reset();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            stall_req = 5'($urandom_range(1, 31));
            tick();
        end
        stall_req = '0;
        total++;
        if (s_stall_cycles !== 4'd15) begin
            bad++; $display("FAIL sat_small got=%0d exp=15", s_stall_cycles);
        end
        total++;
        if (stall_cycles !== 32'd20) begin
            bad++; $display("FAIL sat_wide got=%0d exp=20", stall_cycles);
        end
        halt_req = 1'b1;
        mem_busy = 1'b1;
        tick();
        tick();
        #2;
        nRST = 1'b0;
        model_clear();
        #1;
        total++;
        if ({state, halt, valid, s_state} !== 10'b0) begin
            bad++; $display("FAIL drain_async_rst got=%b exp=%b", {state, halt, valid, s_state}, 10'b0);
        end
        total++;
        if ({stall_cycles, s_stall_cycles, retired_count} !== 68'b0) begin
            bad++; $display("FAIL drain_rst_counters got=%0h exp=0", {stall_cycles, s_stall_cycles, retired_count});
        end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        mem_busy = 1'b0;
        tick();
        tick();
        total++;
        if ({state, halt} !== 3'b101) begin
            bad++; $display("FAIL fast_halt got=%b exp=%b", {state, halt}, 3'b101);
        end
        #2;
        nRST = 1'b0;
        model_clear();
        #1;
        total++;
        if ({state, halt, s_halt} !== 4'b0) begin
            bad++; $display("FAIL halted_async_rst got=%b exp=%b", {state, halt, s_halt}, 4'b0);
        end
        idle_inputs();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stall();
        test_flush();
        test_flush_over_stall();
        test_halt();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
